// File: rtl/sdma_byte_packer.sv
// Packs low-aligned, byte-strobed beats from a narrow source bus into full-width
// output beats; the final beat of a section may be partial and carries a byte mask.
module sdma_byte_packer #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 32,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_start,
    input  logic [CNT_W-1:0]       i_total_bytes,
    input  logic                   i_din_vld,
    input  logic [IN_BYTES*8-1:0]  i_din,
    input  logic [IN_BYTES-1:0]    i_din_strb,
    output logic                   o_din_ready,
    output logic                   o_dout_vld,
    output logic [OUT_BYTES*8-1:0] o_dout,
    output logic [OUT_BYTES-1:0]   o_dout_strb,
    output logic                   o_dout_last,
    input  logic                   i_dout_ready,
    output logic                   o_busy,
    output logic                   o_section_done,
    output logic                   o_err
);

    localparam int ACC_BYTES = OUT_BYTES + IN_BYTES - 1;
    localparam int LVL_W     = $clog2(ACC_BYTES + 1);
    localparam int POP_W     = $clog2(IN_BYTES + 1);

    typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [7:0]             acc_reg [ACC_BYTES];
    logic [7:0]             acc_next [ACC_BYTES];
    logic [LVL_W-1:0]       lvl_reg, lvl_next;
    logic [CNT_W-1:0]       remain_reg, remain_next;
    logic                   dout_vld_reg, dout_vld_next;
    logic [OUT_BYTES*8-1:0] dout_reg, dout_next;
    logic [OUT_BYTES-1:0]   strb_reg, strb_next;
    logic                   last_reg, last_next;
    logic                   done_reg, done_next;
    logic                   err_reg, err_next;

    logic [POP_W-1:0]       pop, n;
    logic [IN_BYTES-1:0]    strb_inc;
    logic                   contig, accept, load_ok, full_load, part_load;
    logic [LVL_W-1:0]       moved, base;
    logic [7:0]             upper [ACC_BYTES];
    logic [7:0]             din_byte [IN_BYTES];

    // upper[gi] is the byte that lands in lane gi when a full word moves out
    generate
        for (genvar gi = 0; gi < ACC_BYTES; gi++) begin : g_upper
            if (gi + OUT_BYTES < ACC_BYTES) begin : g_src
                assign upper[gi] = acc_reg[gi + OUT_BYTES];
            end else begin : g_zero
                assign upper[gi] = 8'h00;
            end
        end
        for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_din
            assign din_byte[gi] = i_din[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            pop = pop + POP_W'(i_din_strb[i]);
        end
    end

    assign strb_inc    = i_din_strb + IN_BYTES'(1);
    assign contig      = ((i_din_strb & strb_inc) == '0);
    assign n           = (CNT_W'(pop) > remain_reg) ? POP_W'(remain_reg) : pop;
    assign o_din_ready = i_en && (state_reg == PACK) && (lvl_reg < LVL_W'(OUT_BYTES));
    assign accept      = i_din_vld && o_din_ready;
    assign load_ok     = i_en && (!dout_vld_reg || i_dout_ready);
    assign full_load   = load_ok && (lvl_reg >= LVL_W'(OUT_BYTES));
    assign part_load   = load_ok && (state_reg == DRAIN) && (lvl_reg != '0)
                         && (lvl_reg < LVL_W'(OUT_BYTES));
    assign moved       = full_load ? LVL_W'(OUT_BYTES) : (part_load ? lvl_reg : '0);
    assign base        = lvl_reg - (full_load ? LVL_W'(OUT_BYTES) : '0);

    always_comb begin
        state_next    = state_reg;
        remain_next   = remain_reg - (accept ? CNT_W'(n) : '0);
        lvl_next      = lvl_reg - moved + (accept ? LVL_W'(n) : '0);
        err_next      = err_reg;
        done_next     = 1'b0;
        dout_vld_next = (full_load || part_load) ? 1'b1
                      : ((dout_vld_reg && i_dout_ready) ? 1'b0 : dout_vld_reg);
        if (accept && ((CNT_W'(pop) > remain_reg) || !contig)) begin
            err_next = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    err_next    = 1'b0;
                    remain_next = i_total_bytes;
                    if (i_total_bytes != '0) begin
                        state_next = PACK;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            PACK: begin
                if (remain_next == '0) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dout_vld_reg && i_dout_ready && last_reg) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < ACC_BYTES; i++) begin
            acc_next[i] = full_load ? upper[i] : acc_reg[i];
            for (int j = 0; j < IN_BYTES; j++) begin
                if (accept && (j < int'(n)) && (int'(base) + j == i)) begin
                    acc_next[i] = din_byte[j];
                end
            end
        end
    end

    // Output register only changes on a load, so it is stable while stalled
    always_comb begin
        dout_next = dout_reg;
        strb_next = strb_reg;
        last_next = last_reg;
        if (full_load) begin
            for (int i = 0; i < OUT_BYTES; i++) begin
                dout_next[i*8 +: 8] = acc_reg[i];
            end
            strb_next = '1;
            last_next = (remain_next == '0) && (lvl_next == '0);
        end else if (part_load) begin
            for (int i = 0; i < OUT_BYTES; i++) begin
                if (i < int'(lvl_reg)) begin
                    dout_next[i*8 +: 8] = acc_reg[i];
                    strb_next[i]        = 1'b1;
                end else begin
                    dout_next[i*8 +: 8] = 8'h00;
                    strb_next[i]        = 1'b0;
                end
            end
            last_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            lvl_reg      <= '0;
            remain_reg   <= '0;
            dout_vld_reg <= 1'b0;
            dout_reg     <= '0;
            strb_reg     <= '0;
            last_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            for (int i = 0; i < ACC_BYTES; i++) begin
                acc_reg[i] <= 8'h00;
            end
        end else begin
            state_reg    <= state_next;
            lvl_reg      <= lvl_next;
            remain_reg   <= remain_next;
            dout_vld_reg <= dout_vld_next;
            dout_reg     <= dout_next;
            strb_reg     <= strb_next;
            last_reg     <= last_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            for (int i = 0; i < ACC_BYTES; i++) begin
                acc_reg[i] <= acc_next[i];
            end
        end
    end

    assign o_dout_vld     = dout_vld_reg;
    assign o_dout         = dout_reg;
    assign o_dout_strb    = strb_reg;
    assign o_dout_last    = last_reg;
    assign o_busy         = (state_reg != IDLE);
    assign o_section_done = done_reg;
    assign o_err          = err_reg;

endmodule
